// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests and buffers
// returned words in a small queue that feeds the IF/ID register.
module fetch_queue_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall_D,
  input  logic        PCSrc_E,
  input  logic [63:0] PCTarget_E,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        Valid_F,
  output logic [31:0] Instr_F,
  output logic [63:0] PC_F,
  output logic [63:0] PCPlus4_F
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic [63:0]     r_fetch_pc;
  logic [63:0]     r_resp_pc;
  logic [31:0]     r_q_instr [DEPTH];
  logic [63:0]     r_q_pc    [DEPTH];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] r_outst;
  logic [CntW-1:0] r_discard;

  logic [CntW:0]   w_credit;
  logic            w_req;
  logic            w_issue;
  logic            w_valid;
  logic            w_deq;
  logic            w_drop;
  logic            w_enq;
  logic [CntW-1:0] w_outst_dec;
  logic [63:0]     w_target;
  logic            w_unused_tgt;

  // Queued entries plus in-flight requests may never exceed DEPTH, so a response always fits.
  assign w_credit    = {1'b0, r_count} + {1'b0, r_outst};
  assign w_req       = rst_n && !PCSrc_E && (w_credit < (CntW + 1)'(DEPTH));
  assign w_issue     = w_req && imem_gnt;
  assign w_valid     = (r_count != '0);
  assign w_deq       = w_valid && !Stall_D && !PCSrc_E;
  assign w_drop      = imem_rvalid && (r_discard != '0);
  assign w_enq       = imem_rvalid && !w_drop && !PCSrc_E;
  assign w_outst_dec = r_outst - CntW'(imem_rvalid);
  assign w_target    = {PCTarget_E[63:2], 2'b00};
  assign w_unused_tgt = ^PCTarget_E[1:0];

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      r_outst <= w_outst_dec + CntW'(w_issue);
      if (PCSrc_E) begin
        // Everything still in flight belongs to the wrong path.
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_discard  <= w_outst_dec;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_enq) begin
          r_resp_pc <= r_resp_pc + 64'd4;
          r_tail    <= r_tail + PtrW'(1);
        end
        if (w_deq) r_head <= r_head + PtrW'(1);
        r_count <= r_count + CntW'(w_enq) - CntW'(w_deq);
        if (w_drop) r_discard <= r_discard - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_instr[r_tail] <= imem_rdata;
      r_q_pc[r_tail]    <= r_resp_pc;
    end
  end

  always_comb begin
    Valid_F   = 1'b0;
    Instr_F   = Nop;
    PC_F      = 64'd0;
    PCPlus4_F = 64'd0;
    if (w_valid) begin
      Valid_F   = 1'b1;
      Instr_F   = r_q_instr[r_head];
      PC_F      = r_q_pc[r_head];
      PCPlus4_F = r_q_pc[r_head] + 64'd4;
    end
  end

endmodule
